// File: rtl/cpu_pkg.sv
// Shared CPU constants: multiplier operand width and sequencer state encodings.
package cpu_pkg;

    localparam int MUL_WIDTH = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/mul_step.sv
// One shift-add multiply iteration: conditionally add the multiplicand into hi, then shift {cout,hi,lo} right by one.
module mul_step
    import cpu_pkg::*;
(
    input  logic [MUL_WIDTH-1:0] i_hi,
    input  logic [MUL_WIDTH-1:0] i_lo,
    input  logic [MUL_WIDTH-1:0] i_mcand,
    output logic [MUL_WIDTH-1:0] o_hi,
    output logic [MUL_WIDTH-1:0] o_lo
);

    logic [MUL_WIDTH-1:0] w_addend;
    logic [MUL_WIDTH-1:0] w_sum;
    logic                 w_cout;

    assign w_addend = i_lo[0] ? i_mcand : '0;

    yArith u_add (
        .z    (w_sum),
        .cout (w_cout),
        .a    (i_hi),
        .b    (w_addend),
        .ctrl (1'b0)
    );

    // The carry is kept as the new msb, so no product bit is ever lost.
    assign o_hi = {w_cout, w_sum[MUL_WIDTH-1:1]};
    assign o_lo = {w_sum[0], i_lo[MUL_WIDTH-1:1]};

endmodule

// File: rtl/yArith.sv
// 32-bit adder/subtractor datapath: ctrl=0 adds, ctrl=1 subtracts (a - b) with carry out.
module yArith (
    output logic [31:0] z,
    output logic        cout,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ctrl
);

    logic [31:0] w_b;

    assign w_b         = ctrl ? ~b : b;
    assign {cout, z}   = {1'b0, a} + {1'b0, w_b} + {32'b0, ctrl};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 unsigned shift-add multiplier with valid/ready operand and result handshakes.
// Optional build macro MUL_SEQ_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for operands, start_ready high
// RUN   | one shift-add iteration per clock
// DONE  | product held on hi/lo until res_ready
module mul_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    generate
        if (WIDTH != MUL_WIDTH) begin : g_bad_width
            $error("mul_seq_ctrl: WIDTH must be 32");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_take;
    logic             w_last;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;

    assign start_ready = (r_state == IDLE);
    assign res_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign w_accept    = start_valid & start_ready;
    assign w_take      = res_valid & res_ready;

    mul_step u_step (
        .i_hi    (r_hi),
        .i_lo    (r_lo),
        .i_mcand (r_mcand),
        .o_hi    (w_step_hi),
        .o_lo    (w_step_lo)
    );

`ifdef MUL_SEQ_EARLY_EXIT_EN
    // Only bits above the one consumed this edge matter, so bit 0 of the shadow is never stored.
    logic [WIDTH-2:0]   r_mq_hi;
    logic               w_early;
    logic [CNT_W-1:0]   w_shamt;
    logic [2*WIDTH-1:0] w_shifted;

    assign w_early   = (r_mq_hi == '0);
    assign w_shamt   = r_cnt - CNT_W'(1);
    assign w_shifted = {w_step_hi, w_step_lo} >> w_shamt;
    assign {w_next_hi, w_next_lo} = w_early ? w_shifted : {w_step_hi, w_step_lo};
    assign w_last    = w_early | (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mq_hi <= '0;
        end else if (w_accept) begin
            r_mq_hi <= b[WIDTH-1:1];
        end else if (r_state == RUN) begin
            r_mq_hi <= r_mq_hi >> 1;
        end
    end
`else
    assign w_next_hi = w_step_hi;
    assign w_next_lo = w_step_lo;
    assign w_last    = (r_cnt == CNT_W'(1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand <= a;
                        r_lo    <= b;
                        r_hi    <= '0;
                        r_cnt   <= CNT_W'(WIDTH);
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_hi  <= w_next_hi;
                    r_lo  <= w_next_lo;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (w_take) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
